// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the TPU output stage (argmax classifier).
// Optional build macro used by the classifier: ARGMAX_SECOND_BEST_EN.
package tpu_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 8;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/float8_gt.sv
// Strict greater-than for sign-magnitude Float8 scores; +0 and -0 compare equal.
// Bit W-1 is the sign, bits [W-2:0] the magnitude (exponent above mantissa).
module float8_gt #(
    parameter int W = tpu_pkg::SCORE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    logic a_zero;
    logic b_zero;
    logic a_neg;
    logic b_neg;

    // A zero magnitude counts as non-negative whatever its sign bit says.
    assign a_zero = (a[W-2:0] == '0);
    assign b_zero = (b[W-2:0] == '0);
    assign a_neg  = a[W-1] & ~a_zero;
    assign b_neg  = b[W-1] & ~b_zero;

    always_comb begin
        // NOTE: assign a default first so no path through the block leaves gt unassigned (no latch).
        gt = 1'b0;
        if (!a_neg && b_neg) begin
            gt = 1'b1;
        end else if (!a_neg && !b_neg) begin
            gt = (a[W-2:0] > b[W-2:0]);
        end else if (a_neg && b_neg) begin
            gt = (a[W-2:0] < b[W-2:0]);
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES Float8 scores, one comparison per cycle.
// Define ARGMAX_SECOND_BEST_EN to add the runner-up index output second_digit.
module argmax_classifier #(
    parameter int NUM_CLASSES = tpu_pkg::NUM_CLASSES,
    parameter int SCORE_W     = tpu_pkg::SCORE_W
) (
    input  logic                           clk,
    input  logic                           iRst_n,
    input  logic                           ena,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic                           overflow_in,
    output logic [tpu_pkg::IDX_W-1:0]      digit,
    output logic [SCORE_W-1:0]             max_score,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
`ifdef ARGMAX_SECOND_BEST_EN
    ,
    output logic [tpu_pkg::IDX_W-1:0]      second_digit
`endif
);

    localparam int IDX_W = tpu_pkg::IDX_W;
    // idx reaching this value means every class has been compared.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES);

    tpu_pkg::state_t    state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SCORE_W-1:0] best_q;
    logic [IDX_W-1:0]   best_idx_q;
    logic               ovf_q;
    logic [SCORE_W-1:0] score_q [NUM_CLASSES];
    logic [SCORE_W-1:0] cur_score;
    logic               cur_gt_best;

`ifdef ARGMAX_SECOND_BEST_EN
    logic [SCORE_W-1:0] sec_q;
    logic [IDX_W-1:0]   sec_idx_q;
    logic               sec_valid_q;
    logic               cur_gt_sec;
`endif

    // NOTE: the captured score bank is pure datapath, always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (ena && state_q == tpu_pkg::IDLE && start) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                score_q[k] <= scores[k*SCORE_W +: SCORE_W];
            end
        end
    end

    always_comb begin
        cur_score = '0;
        if (idx_q < LAST_IDX) begin
            cur_score = score_q[idx_q];
        end
    end

    float8_gt #(.W(SCORE_W)) u_gt_best (
        .a  (cur_score),
        .b  (best_q),
        .gt (cur_gt_best)
    );

`ifdef ARGMAX_SECOND_BEST_EN
    float8_gt #(.W(SCORE_W)) u_gt_sec (
        .a  (cur_score),
        .b  (sec_q),
        .gt (cur_gt_sec)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= tpu_pkg::IDLE;
            idx_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            ovf_q        <= 1'b0;
            digit        <= '0;
            max_score    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
`ifdef ARGMAX_SECOND_BEST_EN
            sec_q        <= '0;
            sec_idx_q    <= '1;
            sec_valid_q  <= 1'b0;
            second_digit <= '1;
`endif
        end else if (ena) begin
            case (state_q)
                tpu_pkg::IDLE: begin
                    if (start) begin
                        best_q      <= scores[SCORE_W-1:0];
                        best_idx_q  <= '0;
                        idx_q       <= IDX_W'(1);
                        ovf_q       <= overflow_in;
                        busy        <= 1'b1;
                        state_q     <= tpu_pkg::SCAN;
`ifdef ARGMAX_SECOND_BEST_EN
                        sec_valid_q <= 1'b0;
                        sec_idx_q   <= '1;
`endif
                    end
                end

                tpu_pkg::SCAN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q      <= tpu_pkg::DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        digit        <= best_idx_q;
                        max_score    <= best_q;
                        overflow     <= ovf_q;
`ifdef ARGMAX_SECOND_BEST_EN
                        second_digit <= sec_idx_q;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        // Strictly greater only: ties leave the lower index in place.
                        if (cur_gt_best) begin
                            best_q      <= cur_score;
                            best_idx_q  <= idx_q;
`ifdef ARGMAX_SECOND_BEST_EN
                            sec_q       <= best_q;
                            sec_idx_q   <= best_idx_q;
                            sec_valid_q <= 1'b1;
`endif
                        end
`ifdef ARGMAX_SECOND_BEST_EN
                        else if (!sec_valid_q || cur_gt_sec) begin
                            sec_q       <= cur_score;
                            sec_idx_q   <= idx_q;
                            sec_valid_q <= 1'b1;
                        end
`endif
                    end
                end

                tpu_pkg::DONE: begin
                    done    <= 1'b0;
                    idx_q   <= '0;
                    state_q <= tpu_pkg::IDLE;
                end

                default: begin
                    state_q <= tpu_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed, randomized and control scenarios.
// Expected results come from a signed-integer ranking model of the Float8 scores.
module tb_argmax_classifier;

    localparam int N = 10;

    logic           clk = 1'b0;
    logic           iRst_n = 1'b0;
    logic           ena = 1'b0;
    logic           start = 1'b0;
    logic           overflow_in = 1'b0;
    logic [N*8-1:0] scores = '0;
    logic [3:0]     digit;
    logic [7:0]     max_score;
    logic           busy;
    logic           done;
    logic           overflow;
`ifdef ARGMAX_SECOND_BEST_EN
    logic [3:0]     second_digit;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sc [N];

    always #5 clk = ~clk;

    argmax_classifier dut (
        .clk          (clk),
        .iRst_n       (iRst_n),
        .ena          (ena),
        .start        (start),
        .scores       (scores),
        .overflow_in  (overflow_in),
        .digit        (digit),
        .max_score    (max_score),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
`ifdef ARGMAX_SECOND_BEST_EN
        ,
        .second_digit (second_digit)
`endif
    );

    // Float8 score as a signed integer: sign-magnitude, so +0 and -0 both map to 0.
    function automatic int f8_val(input logic [7:0] s);
        return s[7] ? -int'(s[6:0]) : int'(s[6:0]);
    endfunction

    // Winner = largest value, lowest index on ties; runner-up = same rule over the rest.
    function automatic void ref_rank(output int bi, output int si);
        bi = 0;
        for (int i = 1; i < N; i++)
            if (f8_val(sc[i]) > f8_val(sc[bi])) bi = i;
        si = -1;
        for (int i = 0; i < N; i++)
            if (i != bi && (si < 0 || f8_val(sc[i]) > f8_val(sc[si]))) si = i;
    endfunction

    // Presents sc[] with a one-cycle start pulse; returns just after the sampling edge.
    task automatic start_run(input logic ovf);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) scores[k*8 +: 8] = sc[k];
        overflow_in = ovf;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        overflow_in = 1'b0;
    endtask

    // Counts rising edges until done is seen; lat = -1 if the budget runs out.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL reset_digit: got %0d want 0", digit); end
        n_cmp++; if (max_score !== 8'h00) begin n_err++; $display("FAIL reset_max: got %0h want 0", max_score); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef ARGMAX_SECOND_BEST_EN
        n_cmp++; if (second_digit !== 4'hF) begin n_err++; $display("FAIL reset_second: got %0h want f", second_digit); end
`endif
        #2 iRst_n = 1'b1;
    endtask

    task automatic test_directed();
        int exp_d [5] = '{3, 0, 7, 0, 2};
        logic [7:0] exp_m [5] = '{8'h55, 8'h40, 8'h81, 8'h80, 8'h60};
        logic exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, bi, si;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin for (int i = 0; i < N; i++) sc[i] = 8'h20; sc[9] = 8'h10; sc[3] = 8'h55; end
                1: begin for (int i = 0; i < N; i++) sc[i] = 8'h40; end
                2: begin for (int i = 0; i < N; i++) sc[i] = 8'h90 + 8'(i); sc[7] = 8'h81; end
                3: begin for (int i = 0; i < N; i++) sc[i] = 8'h8A; sc[0] = 8'h80; sc[5] = 8'h00; end
                default: begin for (int i = 0; i < N; i++) sc[i] = 8'h10; sc[2] = 8'h60; sc[8] = 8'h50; end
            endcase
            ref_rank(bi, si);
            start_run(exp_o[c]);
            @(negedge clk);
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b want 1", c, busy); end
            wait_done(30, lat);
            n_cmp++; if (lat != 10) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 10", c, lat); end
            n_cmp++; if (digit !== 4'(exp_d[c])) begin n_err++; $display("FAIL dir%0d_digit: got %0d want %0d", c, digit, exp_d[c]); end
            n_cmp++; if (max_score !== exp_m[c]) begin n_err++; $display("FAIL dir%0d_max: got %0h want %0h", c, max_score, exp_m[c]); end
            n_cmp++; if (overflow !== exp_o[c]) begin n_err++; $display("FAIL dir%0d_overflow: got %b want %b", c, overflow, exp_o[c]); end
`ifdef ARGMAX_SECOND_BEST_EN
            n_cmp++; if (second_digit !== 4'(si)) begin n_err++; $display("FAIL dir%0d_second: got %0d want %0d", c, second_digit, si); end
`endif
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [5] = '{8'h00, 8'h80, 8'h40, 8'hC0, 8'h41};
        int lat, bi, si;
        logic ovf;
        for (int it = 0; it < 12; it++) begin
            // Half the runs draw from a tiny pool so ties and signed zeros are frequent.
            if (($urandom & 1) == 1) begin
                for (int k = 0; k < N; k++) sc[k] = pool[$urandom_range(0, 4)];
            end else begin
                for (int k = 0; k < N; k++) sc[k] = 8'($urandom);
            end
            ovf = 1'($urandom_range(0, 1));
            ref_rank(bi, si);
            start_run(ovf);
            wait_done(30, lat);
            n_cmp++; if (lat != 10) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 10", it, lat); end
            n_cmp++; if (digit !== 4'(bi)) begin n_err++; $display("FAIL rnd%0d_digit: got %0d want %0d", it, digit, bi); end
            n_cmp++; if (max_score !== sc[bi]) begin n_err++; $display("FAIL rnd%0d_max: got %0h want %0h", it, max_score, sc[bi]); end
            n_cmp++; if (overflow !== ovf) begin n_err++; $display("FAIL rnd%0d_overflow: got %b want %b", it, overflow, ovf); end
`ifdef ARGMAX_SECOND_BEST_EN
            n_cmp++; if (second_digit !== 4'(si)) begin n_err++; $display("FAIL rnd%0d_second: got %0d want %0d", it, second_digit, si); end
`endif
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, bi, si, n_done;
        for (int i = 0; i < N; i++) sc[i] = 8'h05;
        sc[4] = 8'h70;
        start_run(1'b1);
        wait_done(30, lat);
        for (int i = 0; i < N; i++) sc[i] = 8'h01;
        sc[6] = 8'h33;
        start_run(1'b1);
        repeat (5) @(posedge clk);
        #3 iRst_n = 1'b0;
        #1;
        n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL abort_digit: got %0d want 0", digit); end
        n_cmp++; if (max_score !== 8'h00) begin n_err++; $display("FAIL abort_max: got %0h want 0", max_score); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL abort_overflow: got %b want 0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        #2 iRst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
        for (int k = 0; k < N; k++) sc[k] = 8'($urandom);
        ref_rank(bi, si);
        start_run(1'b0);
        wait_done(30, lat);
        n_cmp++; if (lat != 10) begin n_err++; $display("FAIL restart_latency: got %0d want 10", lat); end
        n_cmp++; if (digit !== 4'(bi)) begin n_err++; $display("FAIL restart_digit: got %0d want %0d", digit, bi); end
    endtask

    task automatic test_ena_stall();
        int lat, bi, si;
        for (int k = 0; k < N; k++) sc[k] = 8'($urandom_range(0, 127));
        sc[1] = 8'h7F;
        ref_rank(bi, si);
        start_run(1'b1);
        @(posedge clk); #1;
        // A second start mid-scan with different data must be ignored.
        for (int k = 0; k < N; k++) scores[k*8 +: 8] = 8'h7F;
        overflow_in = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) scores[k*8 +: 8] = 8'($urandom);
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b want 1", busy); end
        ena = 1'b1;
        wait_done(30, lat);
        if (lat > 0) lat = lat + 6;
        n_cmp++; if (lat != 13) begin n_err++; $display("FAIL stall_latency: got %0d want 13", lat); end
        n_cmp++; if (digit !== 4'(bi)) begin n_err++; $display("FAIL stall_digit: got %0d want %0d", digit, bi); end
        n_cmp++; if (max_score !== sc[bi]) begin n_err++; $display("FAIL stall_max: got %0h want %0h", max_score, sc[bi]); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL stall_overflow: got %b want 1", overflow); end
    endtask

    task automatic test_done_freeze();
        int lat, bi, si;
        for (int k = 0; k < N; k++) sc[k] = 8'($urandom);
        ref_rank(bi, si);
        start_run(1'b0);
        wait_done(30, lat);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL freeze_done%0d: got %b want 1", k, done); end
        end
        n_cmp++; if (digit !== 4'(bi)) begin n_err++; $display("FAIL freeze_digit: got %0d want %0d", digit, bi); end
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL freeze_release_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL freeze_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_start_with_done();
        int lat, bi, si, n_done, n_busy;
        for (int k = 0; k < N; k++) sc[k] = 8'h02;
        sc[8] = 8'h44;
        ref_rank(bi, si);
        start_run(1'b0);
        wait_done(30, lat);
        // Start raised while done is high: sampled in DONE, so it must be dropped.
        for (int k = 0; k < N; k++) scores[k*8 +: 8] = 8'h01;
        scores[7:0] = 8'h7E;
        overflow_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        overflow_in = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL late_start_done: got %0d pulses want 0", n_done); end
        n_cmp++; if (n_busy != 0) begin n_err++; $display("FAIL late_start_busy: got %0d cycles want 0", n_busy); end
        n_cmp++; if (digit !== 4'(bi)) begin n_err++; $display("FAIL late_start_digit: got %0d want %0d", digit, bi); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL late_start_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_scan();
        test_ena_stall();
        test_done_freeze();
        test_start_with_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: NUM_CLASSES, default 10, number of 8-bit scores scanned.
REQ-002 Parameter: SCORE_W, default 8, width of one Float8 score.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 iRst_n  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  high: block advances; low: all state and outputs freeze.
REQ-006 start  input  1  one-cycle pulse: scores valid, begin classification.
REQ-007 scores  input  NUM_CLASSES*SCORE_W  score k at bits [8k+7 -: 8], class 0 in LSBs.
REQ-008 overflow_in  input  1  overflow flag from upstream FC stage, sampled with start.
REQ-009 digit  output  4  index of largest score (0..9).
REQ-010 max_score  output  8  value of largest score.
REQ-011 busy  output  1  high while scanning.
REQ-012 done  output  1  one-cycle pulse when digit/max_score are valid.
REQ-013 overflow  output  1  overflow_in captured at start.

Function
REQ-014 Score format: bit 7 sign, bits [6:0] magnitude (exponent above mantissa), so ordering is sign-magnitude.
REQ-015 Greater-than rule: positive beats negative; both positive larger magnitude wins; both negative smaller magnitude wins; +0 (0x00) equals -0 (0x80).
REQ-016 States IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after class NUM_CLASSES-1 compared, DONE->IDLE next cycle.
REQ-017 On start in IDLE: capture scores and overflow_in, best=score 0, best_idx=0, idx=1, busy=1.
REQ-018 SCAN compares one score per cycle; replace best only on strictly greater, so ties resolve to lowest index.
REQ-019 Latency: done pulses exactly NUM_CLASSES cycles after the start-sampling edge (10 cycles default).
REQ-020 digit, max_score, overflow update only on the DONE transition and hold until next DONE.
REQ-021 start while busy or in DONE is ignored; captured scores are unaffected by later scores changes.
REQ-022 start asserted on the same cycle as done: ignored; upstream must re-pulse.
REQ-023 ena low: state, idx, best registers and all outputs hold; done stays high if frozen in DONE and pulses once total.

Reset
REQ-024 iRst_n low asynchronously forces IDLE, digit=0, max_score=0, busy=0, done=0, overflow=0, idx=0.
REQ-025 Reset mid-scan aborts; no done is produced for the aborted run.

Configuration
REQ-026 Macro ARGMAX_SECOND_BEST_EN defined: adds output second_digit (4 bits, reset 4'hF) holding runner-up index, updated with digit.
REQ-027 With macro: new>best moves best to second; else new>second (or second empty) replaces second; ties keep lower index.
REQ-028 Without macro: no second_digit port, no runner-up logic.

Structure
REQ-029 Shared package tpu_pkg holds NUM_CLASSES, SCORE_W, IDX_W=4 and the state encoding (IDLE=2'b00, SCAN=2'b01, DONE=2'b10).
REQ-030 One sub-module float8_gt: combinational sign-magnitude strict greater-than per REQ-015.

Verification
REQ-031 Scores {9:0x10,...,3:0x55,...others 0x20}, start -> done at cycle 10, digit=3, max_score=0x55.
REQ-032 All scores 0x40 -> digit=0 (tie rule); all negative, class 7=0x81 smallest magnitude -> digit=7, max_score=0x81.
REQ-033 Score 0=0x80, score 5=0x00, rest negative -> digit=0 (±0 equal).
REQ-034 Reset pulse at cycle 5 of scan -> outputs zero, no done; new start -> normal result 10 cycles later.
REQ-035 ena low for 3 cycles mid-scan -> done at cycle 13, result unchanged; start during scan ignored.
REQ-036 With ARGMAX_SECOND_BEST_EN: class 2=0x60, class 8=0x50 -> digit=2, second_digit=8; overflow_in=1 at start -> overflow=1 at done.
